// File: rtl/mux_pipe_arb_pkg.sv
// rtl/mux_pipe_arb_pkg.sv - shared NOC flit constants, arbiter state type and round-robin pick helper
package mux_pipe_arb_pkg;

    localparam int NOCDataH = 144;
    localparam int LAST_BIT = NOCDataH - 1;
    localparam int MAX_IN   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

    // First requester at or after ptr, wrapping at numIn; one-hot, zero when nothing requests
    function automatic logic [MAX_IN-1:0] rr_pick(
        input logic [MAX_IN-1:0] req,
        input logic [2:0]        ptr,
        input int                numIn
    );
        logic [MAX_IN-1:0] gnt;
        logic              found;
        logic [2:0]        idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_IN; k++) begin
            idx = 3'((int'(ptr) + k) % numIn);
            if (k < numIn && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mux_pipe_arb_if.sv
// rtl/mux_pipe_arb_if.sv - N upstream enq pipes plus one shared downstream enq pipe
interface mux_pipe_arb_if
    import mux_pipe_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = NOCDataH
);
    logic [NUM_IN-1:0]       in_enq__ENA;
    logic [NUM_IN*WIDTH-1:0] in_enq_v;
    logic [NUM_IN-1:0]       in_enq__RDY;
    logic                    out_enq__ENA;
    logic [WIDTH-1:0]        out_enq_v;
    logic                    out_enq__RDY;

    // master: requesters and shared-pipe sink; slave: the arbiter itself
    modport master (
        output in_enq__ENA, in_enq_v, out_enq__RDY,
        input  in_enq__RDY, out_enq__ENA, out_enq_v
    );

    modport slave (
        input  in_enq__ENA, in_enq_v, out_enq__RDY,
        output in_enq__RDY, out_enq__ENA, out_enq_v
    );
endinterface

// File: rtl/mux_pipe_arb_rr_arbiter.sv
// rtl/mux_pipe_arb_rr_arbiter.sv - combinational request/pointer to one-hot round-robin grant
module rr_arbiter
    import mux_pipe_arb_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] ptr,
    output logic [NUM_IN-1:0]         grant
);
    logic [MAX_IN-1:0] pick;
    logic              unusedPickHi;

    assign pick         = rr_pick(MAX_IN'(req), 3'(ptr), NUM_IN);
    assign grant        = pick[NUM_IN-1:0];
    assign unusedPickHi = ^pick;
endmodule

// File: rtl/mux_pipe_arb.sv
// rtl/mux_pipe_arb.sv - packet-locking round-robin N:1 pipe merge, per-input packet counters under MUX_PIPE_ARB_STATS_EN
module mux_pipe_arb
    import mux_pipe_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = NOCDataH
`ifdef MUX_PIPE_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic CLK,
    input  logic RST,
    mux_pipe_arb_if.slave bus
`ifdef MUX_PIPE_ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [NUM_IN*CNT_W-1:0] stat_pkt_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_IN);

    arbState_t         state, stateNext;
    logic [PTR_W-1:0]  ptr, ptrNext, grantIdx;
    logic [NUM_IN-1:0] grant, grantNext, pick, rdy;
    logic              obufValid, xfer, xferLast, take;
    logic [WIDTH-1:0]  obuf, grantFlit;

    rr_arbiter #(.NUM_IN(NUM_IN)) uArb (
        .req   (bus.in_enq__ENA),
        .ptr   (ptr),
        .grant (pick)
    );

    // Index and flit of the input currently holding the lock
    always_comb begin
        grantIdx  = '0;
        grantFlit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grantIdx  = PTR_W'(i);
                grantFlit = bus.in_enq_v[i*WIDTH +: WIDTH];
            end
        end
    end

    assign take     = obufValid && bus.out_enq__RDY;
    assign rdy      = (state == LOCKED) ? (grant & {NUM_IN{!obufValid || bus.out_enq__RDY}}) : '0;
    assign xfer     = |(bus.in_enq__ENA & rdy);
    assign xferLast = xfer && grantFlit[WIDTH-1];

    assign bus.in_enq__RDY  = rdy;
    assign bus.out_enq__ENA = take;
    assign bus.out_enq_v    = obufValid ? obuf : '0;

    // Arbitrate in IDLE; hold the lock until the granted input's last flit transfers
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        grantNext = grant;
        case (state)
            IDLE: begin
                if (|bus.in_enq__ENA) begin
                    grantNext = pick;
                    stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if (xferLast) begin
                    stateNext = IDLE;
                    ptrNext   = (grantIdx == PTR_W'(NUM_IN - 1)) ? '0 : grantIdx + 1'b1;
                    grantNext = '0;
                end
            end
        endcase
    end

    // Arbiter state, fairness pointer and held grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            grant <= grantNext;
        end
    end

    // One-flit output buffer; a load in the same cycle as a take keeps it full
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            obufValid <= 1'b0;
            obuf      <= '0;
        end else if (xfer) begin
            obufValid <= 1'b1;
            obuf      <= grantFlit;
        end else if (take) begin
            obufValid <= 1'b0;
        end
    end

`ifdef MUX_PIPE_ARB_STATS_EN
    logic [CNT_W-1:0] pktCnt [NUM_IN];

    // Saturating count of completed packets per input; clear wins over increment
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_IN; i++) pktCnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_IN; i++) pktCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (xferLast && grant[i] && pktCnt[i] != '1) pktCnt[i] <= pktCnt[i] + 1'b1;
            end
        end
    end

    // Flatten counters onto the status bus
    always_comb begin
        stat_pkt_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) stat_pkt_cnt[i*CNT_W +: CNT_W] = pktCnt[i];
    end
`endif

endmodule

// File: tb/tb_mux_pipe_arb.sv
// tb/tb_mux_pipe_arb.sv - directed self-checking bench for mux_pipe_arb (counter checks under MUX_PIPE_ARB_STATS_EN)
module tb_mux_pipe_arb;
    import mux_pipe_arb_pkg::*;

    localparam int N = 4;
    localparam int W = NOCDataH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_pipe_arb_if #(.NUM_IN(N), .WIDTH(W)) bus ();

    logic [N-1:0] ena, hold, accPrev;
    logic [W-1:0] dat [N];
    logic         outRdy;

    assign bus.in_enq__ENA  = ena;
    assign bus.in_enq_v     = {dat[3], dat[2], dat[1], dat[0]};
    assign bus.out_enq__RDY = outRdy;

`ifdef MUX_PIPE_ARB_STATS_EN
    logic         statClr;
    logic [N*4-1:0] statCnt;
    mux_pipe_arb #(.NUM_IN(N), .WIDTH(W), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst), .bus(bus), .stat_clr(statClr), .stat_pkt_cnt(statCnt)
    );
`else
    mux_pipe_arb #(.NUM_IN(N), .WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );
`endif

    int           testCnt = 0;
    int           failCnt = 0;
    int           cyc = 0;
    int           accCnt [N];
    int           base;
    int           startCyc;
    logic [W-1:0] srcQ [N][$];
    logic [W-1:0] outQ [$];
    int           outCyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        accPrev = ena & bus.in_enq__RDY;
        if (bus.out_enq__ENA) begin
            outQ.push_back(bus.out_enq_v);
            outCyc.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] mkFlit(input int src, input int seq, input bit last);
        logic [W-1:0] f;
        f            = '0;
        f[7:0]       = 8'(seq);
        f[15:8]      = 8'(src);
        f[W-2 -: 8]  = 8'(src * 16 + seq + 1);
        f[LAST_BIT]  = last;
        return f;
    endfunction

    function automatic logic [W-1:0] outAt(input int k);
        if (k < outQ.size()) return outQ[k];
        return '1;
    endfunction

    function automatic int cycAt(input int k);
        if (k < outCyc.size()) return outCyc[k];
        return -1000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkF(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ena[i] = (srcQ[i].size() != 0) && !hold[i];
            dat[i] = (srcQ[i].size() != 0) ? srcQ[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (accPrev[i]) begin
                void'(srcQ[i].pop_front());
                accCnt[i]++;
            end
        end
        drive();
    endtask

    task automatic runSteps(input int n);
        repeat (n) step();
    endtask

    task automatic waitAcc(input int i, input int n, input int bound);
        int k;
        k = 0;
        while (accCnt[i] < n && k < bound) begin
            step();
            k++;
        end
        check("wait_accept", 32'(accCnt[i] >= n), 32'd1);
    endtask

    task automatic clearOut();
        outQ.delete();
        outCyc.delete();
    endtask

    initial begin
        rst     = 1'b0;
        ena     = '0;
        hold    = '0;
        accPrev = '0;
        outRdy  = 1'b1;
        for (int i = 0; i < N; i++) begin
            dat[i]    = '0;
            accCnt[i] = 0;
        end
`ifdef MUX_PIPE_ARB_STATS_EN
        statClr = 1'b0;
`endif

        // reset state, asynchronous
        #2 rst = 1'b1;
        #1;
        check("rst_out_ena", 32'(bus.out_enq__ENA), 32'd0);
        checkF("rst_out_v", bus.out_enq_v, '0);
        check("rst_in_rdy", 32'(bus.in_enq__RDY), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_ptr", 32'(dut.ptr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // inputs 0 and 2 each send a 3-flit packet
        clearOut();
        for (int s = 0; s < 3; s++) begin
            srcQ[0].push_back(mkFlit(0, s, s == 2));
            srcQ[2].push_back(mkFlit(2, s, s == 2));
        end
        drive();
        startCyc = cyc;
        runSteps(12);
        check("t1_count", 32'(outQ.size()), 32'd6);
        for (int s = 0; s < 3; s++) begin
            checkF("t1_flit_in0", outAt(s), mkFlit(0, s, s == 2));
            checkF("t1_flit_in2", outAt(3 + s), mkFlit(2, s, s == 2));
        end
        check("t1_first_latency", 32'(cycAt(0) - startCyc), 32'd2);
        check("t1_stream_gap", 32'(cycAt(2) - cycAt(0)), 32'd2);
        check("t1_bubble_gap", 32'(cycAt(3) - cycAt(2)), 32'd2);
        check("t1_ptr", 32'(dut.ptr), 32'd3);
        check("t1_state", 32'(dut.state), 32'(IDLE));

        // reset during the 2nd flit of a packet from input 1
        clearOut();
        base = accCnt[1];
        for (int s = 0; s < 3; s++) srcQ[1].push_back(mkFlit(1, s, s == 2));
        drive();
        waitAcc(1, base + 1, 10);
        #1;
        check("t5_rdy_2nd", 32'(bus.in_enq__RDY), 32'b0010);
        check("t5_ena_1st", 32'(bus.out_enq__ENA), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_out_ena", 32'(bus.out_enq__ENA), 32'd0);
        checkF("t5_rst_out_v", bus.out_enq_v, '0);
        check("t5_rst_in_rdy", 32'(bus.in_enq__RDY), 32'd0);
        for (int i = 0; i < N; i++) srcQ[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("t5_ptr", 32'(dut.ptr), 32'd0);
        check("t5_state", 32'(dut.state), 32'(IDLE));

        // all inputs stream single-flit packets
        clearOut();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) srcQ[i].push_back(mkFlit(i, k, 1'b1));
        drive();
        runSteps(24);
        check("t2_count", 32'(outQ.size()), 32'd8);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                checkF("t2_rr_order", outAt(k * N + i), mkFlit(i, k, 1'b1));
        check("t2_ptr_wrap", 32'(dut.ptr), 32'd0);

        // input 1 four-flit packet with downstream stall after flit 2
        clearOut();
        base = accCnt[1];
        for (int s = 0; s < 4; s++) srcQ[1].push_back(mkFlit(1, s, s == 3));
        drive();
        waitAcc(1, base + 2, 10);
        outRdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_stall_rdy", 32'(bus.in_enq__RDY), 32'd0);
            check("t3_stall_ena", 32'(bus.out_enq__ENA), 32'd0);
            checkF("t3_stall_hold", bus.out_enq_v, mkFlit(1, 1, 1'b0));
            step();
        end
        outRdy = 1'b1;
        runSteps(8);
        check("t3_count", 32'(outQ.size()), 32'd4);
        for (int s = 0; s < 4; s++) checkF("t3_order", outAt(s), mkFlit(1, s, s == 3));

        // input 3 pauses mid-packet while input 0 requests
        clearOut();
        base = accCnt[3];
        for (int s = 0; s < 4; s++) srcQ[3].push_back(mkFlit(3, s, s == 3));
        drive();
        waitAcc(3, base + 2, 10);
        hold[3] = 1'b1;
        srcQ[0].push_back(mkFlit(0, 9, 1'b1));
        drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_in0_blocked", 32'(bus.in_enq__RDY[0]), 32'd0);
            check("t4_grant_held", 32'(dut.grant), 32'b1000);
            check("t4_locked", 32'(dut.state), 32'(LOCKED));
            step();
        end
        hold[3] = 1'b0;
        drive();
        runSteps(12);
        check("t4_count", 32'(outQ.size()), 32'd5);
        for (int s = 0; s < 4; s++) checkF("t4_in3", outAt(s), mkFlit(3, s, s == 3));
        checkF("t4_in0_after", outAt(4), mkFlit(0, 9, 1'b1));

`ifdef MUX_PIPE_ARB_STATS_EN
        // 17 packets on input 0 saturate a 4-bit counter, then clear
        statClr = 1'b1;
        step();
        statClr = 1'b0;
        for (int k = 0; k < 17; k++) srcQ[0].push_back(mkFlit(0, k, 1'b1));
        drive();
        runSteps(40);
        check("st_cnt0_sat", 32'(statCnt[3:0]), 32'd15);
        check("st_cnt_others", 32'(statCnt[15:4]), 32'd0);
        statClr = 1'b1;
        step();
        statClr = 1'b0;
        check("st_clear", 32'(statCnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/mux_pipe_arb.md
Name: mux_pipe_arb

Overview:
- Round-robin, packet-locking arbiter that shares one downstream NOC pipe between NUM_IN upstream pipes.
- Generalises the two-source merge used in front of the NOC ports to N sources with fairness.
- Guarantees that flits of one packet are never interleaved with flits of another.
- Output is registered (one flit buffer), so the shared pipe sees no combinational path from the requesters.

Parameters:
- NUM_IN, 4, number of requesting pipes (2..8).
- WIDTH, 144, flit width (NOCDataH); bit WIDTH-1 is the last-flit flag.
- CNT_W, 16, width of per-input packet counters (optional feature only).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-high.
- in_enq__ENA  input  NUM_IN  per-requester flit valid/request.
- in_enq_v  input  NUM_IN*WIDTH  per-requester flit; requester i occupies slice [i*WIDTH +: WIDTH].
- in_enq__RDY  output  NUM_IN  per-requester accept.
- out_enq__ENA  output  1  flit transfer to the shared pipe.
- out_enq_v  output  WIDTH  flit to the shared pipe.
- out_enq__RDY  input  1  shared pipe can accept.
- stat_clr  input  1  clear counters (MUX_PIPE_ARB_STATS_EN only).
- stat_pkt_cnt  output  NUM_IN*CNT_W  packets granted per input (MUX_PIPE_ARB_STATS_EN only).

Behaviour:
- Reset: the following take effect asynchronously on RST and hold while RST is high.
  - state=IDLE, ptr=0, grant=0, obuf_valid=0, obuf=0.
  - in_enq__RDY=0, out_enq__ENA=0, out_enq_v=0, stat counters=0.
- Transfer rule: an input transfer occurs when in_enq__ENA[i] && in_enq__RDY[i].
  - A requester may hold ENA high while RDY is low. This is a request, and it must keep its flit stable.
- FSM states: IDLE and LOCKED.
- IDLE:
  - in_enq__RDY=0.
  - If any ENA is high, pick the first requester at or after ptr, wrapping modulo NUM_IN. Register the one-hot grant and go to LOCKED next cycle.
  - If no ENA is high, stay in IDLE.
- LOCKED:
  - in_enq__RDY[g] = !obuf_valid || out_enq__RDY. All other RDY bits are 0.
  - On a transfer of the granted input, load obuf with the flit and set obuf_valid.
  - If the transferred flit has bit WIDTH-1 = 1: go to IDLE, set ptr=(g+1) mod NUM_IN, clear grant.
  - ENA of non-granted inputs is ignored until release.
- Output buffer:
  - out_enq__ENA = obuf_valid && out_enq__RDY.
  - out_enq_v = obuf when obuf_valid, else 0.
  - obuf_valid clears on a downstream take with no simultaneous load. A simultaneous take and load keeps it set with the new flit.
  - There is no cycle in which a valid flit is dropped or duplicated.
- Latency and throughput:
  - First request to first accept: 1 cycle (IDLE arbitration).
  - Accept to out_enq__ENA: 1 cycle minimum.
  - Streaming inside a packet: 1 flit/cycle while out_enq__RDY=1.
  - Each packet costs 1 IDLE bubble cycle.
- Boundary conditions:
  - Single-flit packet: locks for exactly 1 accept, then returns to IDLE.
  - Requester drops ENA mid-packet: the lock is held and no other input is granted. A stalled packet stalls the pipe by design.
  - out_enq__RDY=0 with obuf full: in_enq__RDY=0 and the lock is held.
  - ptr wraps from NUM_IN-1 to 0.
  - RST mid-packet: the partial packet is discarded and the state is as at reset. Downstream must tolerate a truncated packet.

Optional Feature:
- MUX_PIPE_ARB_STATS_EN defined:
  - Counter i increments on each last-flit transfer from input i and saturates at all-ones.
  - stat_clr=1 clears all counters synchronously. If stat_clr and an increment occur in the same cycle, the counter becomes 0.
- Not defined: stat_clr and stat_pkt_cnt are absent and no counter logic is built.

Decomposition:
- Shared package mux_pipe_arb_pkg holds:
  - NOCDataH width 144 and LAST_BIT = 143.
  - Arbiter state enum {IDLE, LOCKED}.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module is natural: rr_arbiter, a combinational request/pointer to one-hot grant, reusable by other NOC muxes.

Test Plan:
- Inputs 0 and 2 each send one 3-flit packet, ENA held, out_enq__RDY=1 -> all 3 flits of input 0 (ptr=0), then 1 bubble, then all 3 flits of input 2; ptr ends at 3.
- All 4 inputs continuously send 1-flit packets -> grants in order 0,1,2,3,0; each input gets 1 in 4 packets.
- Input 1 sends a 4-flit packet and out_enq__RDY is low for 5 cycles after flit 2 -> in_enq__RDY[1]=0 for those cycles, flit 2 is held in obuf, no flit is lost or duplicated, order is preserved.
- Input 3 mid-packet (2 of 4 flits sent) drops ENA for 3 cycles while input 0 requests -> input 0 is not granted until input 3's last flit.
- RST asserted during the 2nd flit of a packet -> outputs go to 0 immediately; after release ptr=0 and state=IDLE.
- MUX_PIPE_ARB_STATS_EN with CNT_W=4: 17 packets on input 0 -> counter 0 saturates at 15; stat_clr=1 -> all counters read 0 next cycle.
